// File: rtl/serial_negator_pkg.sv
// Shared types for the digit-serial negator: operation modes and FSM states.
package serial_negator_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_ONES = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/neg_digit.sv
// One K-bit digit of the negator: conditional invert followed by a K-bit add
// of the incoming carry. The only arithmetic in the block.
module neg_digit #(
  parameter int K = 2
) (
  input  logic [K-1:0] x,
  input  logic         inv,
  input  logic         cin,
  output logic [K-1:0] d,
  output logic         cout
);

  logic [K-1:0] x_c;

  // XOR with inv is the per-bit NAND-with-1 when inverting, a buffer otherwise.
  assign x_c       = x ^ {K{inv}};
  assign {cout, d} = {1'b0, x_c} + {{K{1'b0}}, cin};

endmodule

// File: rtl/serial_negator.sv
// Digit-serial two's-complement pass/negate/abs/ones'-complement unit.
// K bits per cycle, LSB digit first, valid/ready on both sides.
module serial_negator
  import serial_negator_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf,
  output logic         out_zero
);

  if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
    $error("serial_negator: requires N >= 2, 1 <= K <= N and N divisible by K");
  end

  localparam int             DIGITS  = N / K;
  localparam int             CW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(DIGITS - 1);
  localparam logic [N-1:0]   MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_t        state;
  logic [N-1:0]  sh;
  logic          carry;
  logic          inv;
  logic          ovf_q;
  logic [CW-1:0] count;

  mode_t         mode;
  logic          inv_init;
  logic          carry_init;
  logic          ovf_init;
  logic [K-1:0]  digit;
  logic          digit_cout;
  logic [N-1:0]  sh_next;

  assign mode = mode_t'(in_mode);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    inv_init   = 1'b0;
    carry_init = 1'b0;
    unique case (mode)
      MODE_PASS: begin inv_init = 1'b0;       carry_init = 1'b0;       end
      MODE_NEG:  begin inv_init = 1'b1;       carry_init = 1'b1;       end
      MODE_ABS:  begin inv_init = in_data[N-1]; carry_init = in_data[N-1]; end
      MODE_ONES: begin inv_init = 1'b1;       carry_init = 1'b0;       end
    endcase
  end

  // Only negating the most negative value is unrepresentable; the carry-out never signals it.
  assign ovf_init = ((mode == MODE_NEG) || (mode == MODE_ABS && in_data[N-1]))
                    && (in_data == MIN_VAL);

  neg_digit #(.K(K)) u_digit (
    .x    (sh[K-1:0]),
    .inv  (inv),
    .cin  (carry),
    .d    (digit),
    .cout (digit_cout)
  );

  // Operand drains from the LSB side while result digits fill from the MSB side.
  assign sh_next = (sh >> K) | (N'(digit) << (N - K));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      sh        <= '0;
      carry     <= 1'b0;
      inv       <= 1'b0;
      ovf_q     <= 1'b0;
      count     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sh       <= in_data;
            inv      <= inv_init;
            carry    <= carry_init;
            ovf_q    <= ovf_init;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          sh    <= sh_next;
          carry <= digit_cout;
          count <= count + 1'b1;
          if (count == LAST) begin
            out_data  <= sh_next;
            out_zero  <= (sh_next == '0);
            out_ovf   <= ovf_q;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_negator.sv
// Scoreboard bench for serial_negator: four instances (N=8, K=1/2/4/8) driven one
// at a time, checked against an integer-arithmetic reference model.
module tb_serial_negator;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] data;
    logic         ovf;
    logic         zero;
    int           acc_cyc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic [1:0] in_mode = 2'b00;
  logic out_ready_dir = 1'b1;
  logic rnd_ready = 1'b1;
  logic bp_random = 1'b0;
  logic out_ready;
  int sel = 1;

  logic         rdy [4];
  logic         ov  [4];
  logic [N-1:0] od  [4];
  logic         oo  [4];
  logic         oz  [4];

  logic         cur_ready, cur_valid, cur_ovf, cur_zero;
  logic [N-1:0] cur_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int prev_acc = 0;
  logic have_prev = 1'b0;
  logic tput_on = 1'b0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  assign out_ready = bp_random ? rnd_ready : out_ready_dir;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int KK = 1 << gi;
    serial_negator #(.N(N), .K(KK)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid && (sel == gi)),
      .in_ready  (rdy[gi]),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (ov[gi]),
      .out_ready (out_ready),
      .out_data  (od[gi]),
      .out_ovf   (oo[gi]),
      .out_zero  (oz[gi])
    );
  end

  assign cur_ready = rdy[sel];
  assign cur_valid = ov[sel];
  assign cur_data  = od[sel];
  assign cur_ovf   = oo[sel];
  assign cur_zero  = oz[sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (K=%0d t=%0t)", name, act, req, 1 << sel, $time);
    end
  endtask

  // Reference: plain signed integer arithmetic, wrapped to N bits.
  function automatic exp_t model(input logic [N-1:0] d, input logic [1:0] m);
    exp_t e;
    int v, r;
    v = $signed(d);
    case (m)
      2'b00:   r = v;
      2'b01:   r = -v;
      2'b10:   r = (v < 0) ? -v : v;
      default: r = ~v;
    endcase
    e.data    = r[N-1:0];
    e.ovf     = (r > 127) || (r < -128);
    e.zero    = (r[N-1:0] == '0);
    e.acc_cyc = 0;
    e.lat     = N / (1 << sel) + 1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic [1:0] m);
    exp_t e;
    int budget;
    budget = 0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    while (!cur_ready && budget < 100) begin
      step();
      budget++;
    end
    if (!cur_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(d, m);
    e.acc_cyc = cyc;
    if (tput_on && have_prev)
      check("throughput", cyc - prev_acc, N / (1 << sel) + 2);
    prev_acc  = cyc;
    have_prev = 1'b1;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int budget;
    budget = 0;
    while (!cur_valid && budget < 50) begin
      step();
      budget++;
    end
    if (!cur_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      step();
      budget++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    step();
    step();
  endtask

  // Monitor: latency on out_valid rise, result compare on the output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (cur_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
      end
      if (cur_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", cur_data, e.data);
        check("out_ovf", cur_ovf, e.ovf);
        check("out_zero", cur_zero, e.zero);
      end
    end
    prev_valid = rst_n && cur_valid;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [7:0] dir_data [7] = '{8'h05, 8'h80, 8'hF6, 8'h3C, 8'h3C, 8'hA5, 8'h00};
    logic [1:0] dir_mode [7] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};

    // Reset state
    sel = 1;
    step();
    step();
    check("reset_in_ready", cur_ready, 1'b0);
    check("reset_out_valid", cur_valid, 1'b0);
    check("reset_out_data", cur_data, 8'h00);
    check("reset_out_ovf", cur_ovf, 1'b0);
    check("reset_out_zero", cur_zero, 1'b0);
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", cur_ready, 1'b1);

    // Directed cases, K=2
    for (int i = 0; i < 7; i++) send(dir_data[i], dir_mode[i]);
    drain();

    // Backpressure: hold DONE, junk in_valid pulses must be ignored
    out_ready_dir = 1'b0;
    send(8'h6B, 2'b01);
    e = model(8'h6B, 2'b01);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      in_valid = i[0];
      in_data  = 8'hFF;
      in_mode  = 2'b00;
      check("bp_out_data_stable", cur_data, e.data);
      check("bp_in_ready_low", cur_ready, 1'b0);
      check("bp_out_valid_held", cur_valid, 1'b1);
      step();
    end
    in_valid = 1'b0;
    out_ready_dir = 1'b1;
    check("bp_handshake_in_ready", cur_ready, 1'b0);
    step();
    check("bp_in_ready_return", cur_ready, 1'b1);
    check("bp_out_valid_drop", cur_valid, 1'b0);
    drain();

    // Reset after two digits of a negate
    send(8'h33, 2'b01);
    step();
    step();
    rst_n = 1'b0;
    step();
    sb.delete();
    check("midrst_out_valid", cur_valid, 1'b0);
    check("midrst_out_data", cur_data, 8'h00);
    check("midrst_out_ovf", cur_ovf, 1'b0);
    check("midrst_out_zero", cur_zero, 1'b0);
    check("midrst_in_ready", cur_ready, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    send(8'h01, 2'b01);
    drain();

    // Exhaustive sweep, out_ready held high, all digit widths
    tput_on = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      have_prev = 1'b0;
      for (int m = 0; m < 4; m++)
        for (int d = 0; d < 256; d++) send(d[7:0], m[1:0]);
      drain();
    end
    tput_on = 1'b0;

    // Random operands, random gaps, random consumer backpressure
    bp_random = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      for (int i = 0; i < 60; i++) begin
        send(8'($urandom), 2'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 2)) step();
      end
      drain();
    end
    bp_random = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
